// File: rtl/sdram_pkg.sv
// Shared constants for the sdramfifo write-side arbiter: state encoding,
// default data width and a constant-safe clog2 helper.
package sdram_pkg;

    localparam int SDRAM_DW = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_G0     = 2'd1;
    localparam logic [1:0] ST_G1     = 2'd2;
    localparam logic [1:0] ST_REPLAY = 2'd3;

    // Loop form keeps this usable in localparam elaboration.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sdram_wr_arb_if.sv
// Producer / sdramfifo side signals of the write arbiter. The slave modport
// is the arbiter's view; master is the producers + fifo view.
interface sdram_wr_arb_if
    import sdram_pkg::*;
#(
    parameter int DW = SDRAM_DW,
    parameter int CW = 16
);
    logic          i_req0_valid;
    logic [DW-1:0] i_req0_data;
    logic          i_req0_last;
    logic          o_req0_ready;
    logic          i_req1_valid;
    logic [DW-1:0] i_req1_data;
    logic          i_req1_last;
    logic          o_req1_ready;
    logic          i_fifo_full;
    logic          o_fifo_wr;
    logic [DW-1:0] o_fifo_wr_data;
    logic          i_replay;
    logic          o_cls_raddr;
    logic [1:0]    o_grant;
    logic          o_busy;
    logic [CW-1:0] o_wcnt0;
    logic [CW-1:0] o_wcnt1;

    modport slave (
        input  i_req0_valid, i_req0_data, i_req0_last,
        input  i_req1_valid, i_req1_data, i_req1_last,
        input  i_fifo_full, i_replay,
        output o_req0_ready, o_req1_ready,
        output o_fifo_wr, o_fifo_wr_data, o_cls_raddr,
        output o_grant, o_busy, o_wcnt0, o_wcnt1
    );

    modport master (
        output i_req0_valid, i_req0_data, i_req0_last,
        output i_req1_valid, i_req1_data, i_req1_last,
        output i_fifo_full, i_replay,
        input  o_req0_ready, o_req1_ready,
        input  o_fifo_wr, o_fifo_wr_data, o_cls_raddr,
        input  o_grant, o_busy, o_wcnt0, o_wcnt1
    );

endinterface

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/sdram_wr_arb.sv
// Burst-locked round-robin write arbiter for the sdramfifo write port, with
// replay (read-address clear) pulses sequenced strictly between bursts.
module sdram_wr_arb
    import sdram_pkg::*;
#(
    parameter int DW        = SDRAM_DW,
    parameter int MAX_BURST = 128,
    parameter int TIMEOUT   = 16,
    parameter int CW        = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    sdram_wr_arb_if.slave  bus
);

    localparam int BW = clog2(MAX_BURST + 1);
    localparam int IW = clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);

    logic [1:0]    state, state_nx;
    logic          last_grant;
    logic          replay_pend;
    logic [BW-1:0] burst_cnt;
    logic [IW-1:0] idle_cnt;
    logic          in_g0, in_g1, in_grant;
    logic          xfer0, xfer1, xfer;
    logic          cur_valid, cur_last;
    logic          burst_end, idle_end;
    logic          wr_q;
    logic [DW-1:0] wr_data_q;

    assign in_g0    = (state == ST_G0);
    assign in_g1    = (state == ST_G1);
    assign in_grant = in_g0 | in_g1;

    assign bus.o_req0_ready = in_g0 & ~bus.i_fifo_full;
    assign bus.o_req1_ready = in_g1 & ~bus.i_fifo_full;

    assign xfer0 = bus.i_req0_valid & bus.o_req0_ready;
    assign xfer1 = bus.i_req1_valid & bus.o_req1_ready;
    assign xfer  = xfer0 | xfer1;

    assign cur_valid = in_g0 ? bus.i_req0_valid : bus.i_req1_valid;
    assign cur_last  = in_g0 ? bus.i_req0_last  : bus.i_req1_last;

    // A stalled-but-valid owner keeps the grant: only valid-low cycles age it.
    assign burst_end = xfer & (cur_last | (burst_cnt == BURST_LAST));
    assign idle_end  = in_grant & ~cur_valid & (idle_cnt == IDLE_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (replay_pend)
                    state_nx = ST_REPLAY;
                else if (bus.i_req0_valid && bus.i_req1_valid)
                    state_nx = last_grant ? ST_G0 : ST_G1;
                else if (bus.i_req0_valid)
                    state_nx = ST_G0;
                else if (bus.i_req1_valid)
                    state_nx = ST_G1;
            end
            ST_G0, ST_G1: begin
                if (burst_end || idle_end)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            replay_pend <= 1'b0;
            burst_cnt   <= '0;
            idle_cnt    <= '0;
            wr_q        <= 1'b0;
            wr_data_q   <= '0;
        end else begin
            state <= state_nx;

            // New requests win over the clear so a pulse during REPLAY is not lost.
            if (bus.i_replay)
                replay_pend <= 1'b1;
            else if (state == ST_REPLAY)
                replay_pend <= 1'b0;

            if (!in_grant) begin
                burst_cnt <= '0;
                idle_cnt  <= '0;
            end else begin
                if (xfer)
                    burst_cnt <= burst_cnt + 1'b1;
                if (cur_valid)
                    idle_cnt <= '0;
                else
                    idle_cnt <= idle_cnt + 1'b1;
            end

            if (state_nx == ST_G0)
                last_grant <= 1'b0;
            else if (state_nx == ST_G1)
                last_grant <= 1'b1;

            wr_q <= xfer;
            if (xfer)
                wr_data_q <= xfer0 ? bus.i_req0_data : bus.i_req1_data;
        end
    end

    assign bus.o_fifo_wr      = wr_q;
    assign bus.o_fifo_wr_data = wr_data_q;
    assign bus.o_cls_raddr    = (state == ST_REPLAY);
    assign bus.o_grant        = {in_g1, in_g0};
    assign bus.o_busy         = (state != ST_IDLE);

    sat_cnt #(.W(CW)) u_wcnt0 (
        .clk (i_clk),
        .rst (i_rst),
        .clr (1'b0),
        .inc (xfer0),
        .q   (bus.o_wcnt0)
    );

    sat_cnt #(.W(CW)) u_wcnt1 (
        .clk (i_clk),
        .rst (i_rst),
        .clr (1'b0),
        .inc (xfer1),
        .q   (bus.o_wcnt1)
    );

endmodule
